multicast_tag_programmer: RTL and testbench
===========================================

// Module: multicast_tag_programmer
// PURPOSE
//  Sequences scan-chain programming of tag IDs into a daisy chain of NUM_CTRL
//  multicast controllers. Software or a host FSM loads one tag per controller
//  into a local tag buffer, then pulses start. The block then drives program
//  and the scan data stream for exactly 2*NUM_CTRL cycles and reports done.
//  It sits between the configuration interface and the first controller's
//  scan_tag_in.
// PARAMETERS
//  ADDRESS_WIDTH  4  width of one tag; must match the controllers
//  NUM_CTRL       8  number of controllers in the chain (>=1)
//  IDX_WIDTH      $clog2(NUM_CTRL) (min 1)  width of the tag-buffer index
// PORTS
//  clk           in   1              clock; all logic on posedge
//  rstb          in   1              asynchronous, active-low reset
//  cfg_wr_en     in   1              write cfg_wr_tag into buffer[cfg_wr_addr]
//  cfg_wr_addr   in   IDX_WIDTH      controller index; 0 = nearest to this block
//  cfg_wr_tag    in   ADDRESS_WIDTH  tag value for that controller
//  start         in   1              begin a programming sequence
//  busy          out  1              sequence in progress
//  done          out  1              one-cycle pulse when the sequence completes
//  program       out  1              to every controller's program input
//  scan_tag_out  out  ADDRESS_WIDTH  to scan_tag_in of controller 0
// BEHAVIOUR
//  - Reset: all outputs 0, tag buffer cleared to 0, FSM in IDLE, counter 0.
//  - Each controller has 2 chain stages (tag_id_reg, then scan_tag_out).
//    Total chain depth is D = 2*NUM_CTRL.
//  - FSM states:
//    IDLE -> SHIFT when start=1.
//    SHIFT -> DONE when shift count j reaches D-1.
//    DONE -> IDLE unconditionally after 1 cycle.
//  - SHIFT: program=1 and busy=1 for exactly D consecutive cycles, j = 0..D-1.
//    j even: scan_tag_out = 0 (filler word).
//    j odd:  scan_tag_out = buffer[NUM_CTRL-1-(j-1)/2].
//    Result: after the last shift, controller k's tag_id_reg = buffer[k].
//  - All outputs are registered.
//    start sampled in cycle T gives program=1 in cycles T+1..T+D.
//    done=1 in cycle T+D+1. busy=0 in that cycle; program=0 from T+D+1.
//  - cfg writes are accepted only in IDLE and are ignored in SHIFT and DONE.
//    A write in the same cycle as start is accepted and is shifted out.
//  - start outside IDLE is ignored and not queued.
//  - If cfg_wr_addr >= NUM_CTRL (non-power-of-2 NUM_CTRL), the write is dropped.
//  - Reset mid-sequence: program drops to 0 immediately (async).
//    The buffer clears. The chain is left partially shifted; the host must
//    reload and restart.
//  - Counter width is $clog2(D). The counter wraps to 0 on DONE, so there
//    is no overflow.
// STRUCTURE
//  - Shared header multicast_defs.vh holds ADDRESS_WIDTH default, the FSM
//    state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the filler value
//    (0).
//  - One sub-module, multicast_tag_buffer: NUM_CTRL x ADDRESS_WIDTH register
//    file with an async-reset clear, one write port and one combinational
//    read port.
//  - The top level holds the FSM, the shift counter, the read-index
//    computation and the output registers.
// TESTING
//  - Bench instantiates NUM_CTRL=4 chained multicast controllers.
//  - Test 1: reset with no writes, then start. Expect program high 8 cycles,
//    done at T+9, and all tag_id_reg = 0.
//  - Test 2: write tags {0:3, 1:5, 2:9, 3:12}, then start. Expect controller
//    k tag_id_reg = 3,5,9,12 respectively, and stream 0,12,0,9,0,5,0,3.
//  - Test 3: pulse start again during SHIFT and write addr 1 = 7 during
//    SHIFT. Expect no restart and tags unchanged (1 still 5). Expect busy
//    contiguous for 8 cycles.
//  - Test 4: write addr 2 = 15 and start in the same cycle. Expect
//    controller 2 tag = 15 after done.
//  - Test 5: assert rstb=0 at j=3. Expect program=0, busy=0, done=0
//    immediately. After release, reload {1,2,3,4} and restart; expect a
//    clean result.
//  - Test 6: NUM_CTRL=3 build, write addr 3. Expect the write dropped, and
//    program held for 6 cycles.

Source files
------------

// File: rtl/multicast_tag_programmer_pkg.sv
// Shared types and constants for the multicast tag programmer.
// Latency: n/a (package only).
// Backpressure: n/a.
package multicast_tag_programmer_pkg;

    // Tag width used by the controllers in the chain unless overridden
    localparam int ADDRESS_WIDTH_DEF = 4;

    // Every bit of the word shifted into the tag_id_reg stages that must not keep a tag
    localparam logic FILLER_BIT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // $clog2 that never returns 0, so single-entry structures still get a 1-bit index
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicast_tag_buffer.sv
// NUM_CTRL x ADDRESS_WIDTH tag register file, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none; writes to an index >= NUM_CTRL are dropped.
module multicast_tag_buffer
    import multicast_tag_programmer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int NUM_CTRL      = 8,
    parameter int IDX_WIDTH     = clog2_min1(NUM_CTRL)
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     wr_en,
    input  logic [IDX_WIDTH-1:0]     wr_addr,
    input  logic [ADDRESS_WIDTH-1:0] wr_tag,
    input  logic [IDX_WIDTH-1:0]     rd_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_tag
);

    // One extra bit so the entry count itself is representable for the range check
    localparam logic [IDX_WIDTH:0] NUM_CTRL_W = (IDX_WIDTH + 1)'(NUM_CTRL);

    logic [ADDRESS_WIDTH-1:0] mem [NUM_CTRL];
    logic                     wr_in_range;
    logic                     rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < NUM_CTRL_W);
    assign rd_in_range = ({1'b0, rd_addr} < NUM_CTRL_W);

    // Storage: cleared on reset, written only for indices that name a real controller
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_tag;
        end
    end

    // Read port; out-of-range indices (non-power-of-2 depth) read as 0
    always_comb begin
        rd_tag = '0;
        if (rd_in_range) begin
            rd_tag = mem[rd_addr];
        end
    end

endmodule

// File: rtl/multicast_tag_programmer.sv
// Shifts one tag per controller (interleaved with filler words) down a 2-stage-per-controller scan chain.
// Latency: start in cycle T -> prog high T+1..T+2*NUM_CTRL, done pulse at T+2*NUM_CTRL+1.
// Backpressure: none; start and cfg writes outside IDLE are ignored, never queued.
module multicast_tag_programmer
    import multicast_tag_programmer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int NUM_CTRL      = 8,
    parameter int IDX_WIDTH     = clog2_min1(NUM_CTRL)
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]     cfg_wr_addr,
    input  logic [ADDRESS_WIDTH-1:0] cfg_wr_tag,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     prog,
    output logic [ADDRESS_WIDTH-1:0] scan_tag_out
);

    localparam int               DEPTH    = 2 * NUM_CTRL;
    localparam int               CNT_W    = clog2_min1(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] FILLER = {ADDRESS_WIDTH{FILLER_BIT}};

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [IDX_WIDTH-1:0]     rd_idx;
    logic [ADDRESS_WIDTH-1:0] rd_tag;
    logic [ADDRESS_WIDTH-1:0] word_nxt;
    logic                     buf_wr_en;

    // Host writes only land while no sequence is running
    assign buf_wr_en = cfg_wr_en && (state == ST_IDLE);

    multicast_tag_buffer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_CTRL      (NUM_CTRL),
        .IDX_WIDTH     (IDX_WIDTH)
    ) u_tag_buffer (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (buf_wr_en),
        .wr_addr (cfg_wr_addr),
        .wr_tag  (cfg_wr_tag),
        .rd_addr (rd_idx),
        .rd_tag  (rd_tag)
    );

    // Next state and shift index; the counter returns to 0 whenever the FSM leaves SHIFT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The farthest controller's tag goes out first, so odd word j reads entry NUM_CTRL-1-(j>>1)
    assign rd_idx   = IDX_WIDTH'(NUM_CTRL - 1 - int'(cnt_nxt >> 1));
    assign word_nxt = cnt_nxt[0] ? rd_tag : FILLER;

    // FSM state and shift counter
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered from the next-state view so they line up with the shift index
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            prog         <= 1'b0;
            scan_tag_out <= '0;
        end else begin
            busy         <= (state_nxt == ST_SHIFT);
            prog         <= (state_nxt == ST_SHIFT);
            done         <= (state_nxt == ST_DONE);
            scan_tag_out <= (state_nxt == ST_SHIFT) ? word_nxt : FILLER;
        end
    end

endmodule

// File: tb/tb_multicast_tag_programmer.sv
// Drives two programmer instances (4- and 3-controller chains) and checks against a buffer model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_multicast_tag_programmer;

    logic       clk = 1'b0;
    logic       rstb;
    logic       wr_en_a, wr_en_b, start_a, start_b;
    logic [1:0] wr_addr;
    logic [3:0] wr_tag;

    logic       busy_a, done_a, prog_a;
    logic       busy_b, done_b, prog_b;
    logic [3:0] so_a, so_b;

    // Controller chain models: tag_id_reg followed by scan_tag_out per controller
    logic [3:0] tg_a [4];
    logic [3:0] sc_a [4];
    logic [3:0] tg_b [3];
    logic [3:0] sc_b [3];

    // Reference buffer contents per instance (index 0 = 4-ctrl, 1 = 3-ctrl)
    logic [3:0] mbuf [2][4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicast_tag_programmer #(.ADDRESS_WIDTH(4), .NUM_CTRL(4)) u_dut_a (
        .clk (clk), .rstb (rstb), .cfg_wr_en (wr_en_a), .cfg_wr_addr (wr_addr),
        .cfg_wr_tag (wr_tag), .start (start_a), .busy (busy_a), .done (done_a),
        .prog (prog_a), .scan_tag_out (so_a)
    );

    multicast_tag_programmer #(.ADDRESS_WIDTH(4), .NUM_CTRL(3)) u_dut_b (
        .clk (clk), .rstb (rstb), .cfg_wr_en (wr_en_b), .cfg_wr_addr (wr_addr),
        .cfg_wr_tag (wr_tag), .start (start_b), .busy (busy_b), .done (done_b),
        .prog (prog_b), .scan_tag_out (so_b)
    );

    always @(posedge clk) begin
        if (prog_a) begin
            tg_a[0] <= so_a;
            for (int k = 1; k < 4; k++) tg_a[k] <= sc_a[k-1];
            for (int k = 0; k < 4; k++) sc_a[k] <= tg_a[k];
        end
    end

    always @(posedge clk) begin
        if (prog_b) begin
            tg_b[0] <= so_b;
            for (int k = 1; k < 3; k++) tg_b[k] <= sc_b[k-1];
            for (int k = 0; k < 3; k++) sc_b[k] <= tg_b[k];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nctrl(input int sel);
        return (sel != 0) ? 3 : 4;
    endfunction

    function automatic logic o_prog(input int sel);
        return (sel != 0) ? prog_b : prog_a;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic o_done(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction
    function automatic logic [3:0] o_scan(input int sel);
        return (sel != 0) ? so_b : so_a;
    endfunction
    function automatic logic [3:0] o_tag(input int sel, input int k);
        return (sel != 0) ? tg_b[k] : tg_a[k];
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start_b = v; else start_a = v;
    endtask
    task automatic set_wr(input int sel, input logic v);
        if (sel != 0) wr_en_b = v; else wr_en_a = v;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 4; k++) mbuf[s][k] = 4'd0;
    endtask

    // Called 1 time unit after a rising edge with the DUT idle
    task automatic do_write(input int sel, input logic [1:0] a, input logic [3:0] t);
        set_wr(sel, 1'b1);
        wr_addr = a;
        wr_tag  = t;
        if (int'(a) < nctrl(sel)) mbuf[sel][a] = t;
        @(posedge clk); #1;
        set_wr(sel, 1'b0);
    endtask

    // One programming sequence: optional same-cycle write, optional mid-shift poke, optional reset at j
    task automatic run_seq(input int sel, input bit poke, input bit wr_same,
                           input logic [1:0] a, input logic [3:0] t, input int rst_j);
        int         d;
        logic [3:0] exp_w;
        d = 2 * nctrl(sel);
        set_start(sel, 1'b1);
        if (wr_same) begin
            set_wr(sel, 1'b1);
            wr_addr = a;
            wr_tag  = t;
            if (int'(a) < nctrl(sel)) mbuf[sel][a] = t;
        end
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        set_wr(sel, 1'b0);
        for (int j = 0; j < d; j++) begin
            exp_w = (j % 2 == 1) ? mbuf[sel][nctrl(sel) - 1 - (j - 1) / 2] : 4'd0;
            check_eq("shift_prog", 32'(o_prog(sel)), 32'd1);
            check_eq("shift_busy", 32'(o_busy(sel)), 32'd1);
            check_eq("shift_done", 32'(o_done(sel)), 32'd0);
            check_eq("shift_word", 32'(o_scan(sel)), 32'(exp_w));
            if (j == rst_j) begin
                rstb = 1'b0;
                #1;
                check_eq("rst_prog", 32'(o_prog(sel)), 32'd0);
                check_eq("rst_busy", 32'(o_busy(sel)), 32'd0);
                check_eq("rst_done", 32'(o_done(sel)), 32'd0);
                clear_model();
                #3;
                rstb = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (poke && j == 2) begin
                set_start(sel, 1'b1);
                set_wr(sel, 1'b1);
                wr_addr = 2'd1;
                wr_tag  = 4'd7;
            end
            if (poke && j == 3) begin
                set_start(sel, 1'b0);
                set_wr(sel, 1'b0);
            end
            @(posedge clk); #1;
        end
        check_eq("end_done", 32'(o_done(sel)), 32'd1);
        check_eq("end_busy", 32'(o_busy(sel)), 32'd0);
        check_eq("end_prog", 32'(o_prog(sel)), 32'd0);
        @(posedge clk); #1;
        check_eq("idle_done", 32'(o_done(sel)), 32'd0);
        check_eq("idle_busy", 32'(o_busy(sel)), 32'd0);
        check_eq("idle_prog", 32'(o_prog(sel)), 32'd0);
        for (int k = 0; k < nctrl(sel); k++)
            check_eq($sformatf("tag%0d_%0d", sel, k), 32'(o_tag(sel, k)), 32'(mbuf[sel][k]));
    endtask

    initial begin
        rstb    = 1'b0;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        wr_addr = 2'd0;
        wr_tag  = 4'd0;
        clear_model();
        #12;
        for (int s = 0; s < 2; s++) begin
            check_eq("reset_prog", 32'(o_prog(s)), 32'd0);
            check_eq("reset_busy", 32'(o_busy(s)), 32'd0);
            check_eq("reset_done", 32'(o_done(s)), 32'd0);
            check_eq("reset_scan", 32'(o_scan(s)), 32'd0);
        end
        #10 rstb = 1'b1;
        @(posedge clk); #1;

        // Empty buffer shifts all zeros
        run_seq(0, 1'b0, 1'b0, 2'd0, 4'd0, -1);

        // Known tags: stream 0,12,0,9,0,5,0,3
        do_write(0, 2'd0, 4'd3);
        do_write(0, 2'd1, 4'd5);
        do_write(0, 2'd2, 4'd9);
        do_write(0, 2'd3, 4'd12);
        run_seq(0, 1'b0, 1'b0, 2'd0, 4'd0, -1);

        // start and write during SHIFT are ignored
        run_seq(0, 1'b1, 1'b0, 2'd0, 4'd0, -1);

        // Write in the same cycle as start is shifted out
        run_seq(0, 1'b0, 1'b1, 2'd2, 4'd15, -1);

        // Reset at j=3, then reload and restart
        run_seq(0, 1'b0, 1'b0, 2'd0, 4'd0, 3);
        do_write(0, 2'd0, 4'd1);
        do_write(0, 2'd1, 4'd2);
        do_write(0, 2'd2, 4'd3);
        do_write(0, 2'd3, 4'd4);
        run_seq(0, 1'b0, 1'b0, 2'd0, 4'd0, -1);

        // 3-controller chain: index 3 does not exist, its write must be dropped
        do_write(1, 2'd0, 4'd6);
        do_write(1, 2'd1, 4'd10);
        do_write(1, 2'd2, 4'd13);
        do_write(1, 2'd3, 4'd15);
        run_seq(1, 1'b0, 1'b0, 2'd0, 4'd0, -1);
        run_seq(1, 1'b0, 1'b1, 2'd3, 4'd8, -1);

        // Randomized sequences on both instances
        for (int it = 0; it < 14; it++) begin
            int         sel;
            int         nw;
            sel = int'($urandom_range(0, 1));
            nw  = int'($urandom_range(0, 4));
            for (int w = 0; w < nw; w++)
                do_write(sel, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            run_seq(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
